// File: rtl/cond_exec_unit.sv
// Conditional execution unit: ARM-style condition evaluation against a
// registered flag set, write gating for branch/register/memory requests,
// and predicated blocks of up to PRED_MAX slots opened by an it_start
// instruction.
module cond_exec_unit #(
    parameter  int FLAG_W   = 4,
    parameter  int PRED_MAX = 4,
    localparam int LEN_W    = $clog2(PRED_MAX + 1),
    localparam int IDX_W    = (PRED_MAX > 1) ? $clog2(PRED_MAX) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic [3:0]        cond_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    input  logic [FLAG_W-1:0] flag_w_i,
    input  logic              pcs_i,
    input  logic              reg_w_i,
    input  logic              mem_w_i,
    input  logic              it_start_i,
    input  logic [3:0]        it_cond_i,
    input  logic [LEN_W-1:0]  it_len_i,
    input  logic [PRED_MAX-1:0] it_mask_i,
    input  logic              flush_i,
    output logic              pcsrc_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              cond_ex_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              it_active_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          base_q, base_d;
    logic [PRED_MAX-1:0] mask_q, mask_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic       fire;
    logic       ce;
    logic       wrEn;
    logic       itLenOk;
    logic [3:0] effCond;

    // Flags are {N,Z,C,V} in the low nibble; upper bits never affect decoding.
    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic pass;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    pass = z;
            4'd1:    pass = ~z;
            4'd2:    pass = c;
            4'd3:    pass = ~c;
            4'd4:    pass = n;
            4'd5:    pass = ~n;
            4'd6:    pass = v;
            4'd7:    pass = ~v;
            4'd8:    pass = c & ~z;
            4'd9:    pass = ~c | z;
            4'd10:   pass = (n == v);
            4'd11:   pass = (n != v);
            4'd12:   pass = ~z & (n == v);
            4'd13:   pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

    // Any it_start instruction is a control marker and never writes anything;
    // reset additionally blocks every write while asserted.
    assign fire    = valid_i & ~stall_i & ~flush_i;
    assign wrEn    = fire & ce & ~it_start_i & ~reset;
    assign itLenOk = (it_len_i != '0) && (it_len_i <= LEN_W'(PRED_MAX));

    // Inside a block the slot's condition comes from the latched base and the
    // then/else mask; an AL/NV base makes every slot unconditional.
    always_comb begin
        effCond = cond_i;
        if (state_q == ACTIVE) begin
            if (base_q[3:1] == 3'b111) begin
                effCond = 4'hE;
            end else if (mask_q[idx_q]) begin
                effCond = base_q;
            end else begin
                effCond = {base_q[3:1], ~base_q[0]};
            end
        end
        ce = condPass(effCond, flags_q[3:0]);
    end

    assign cond_ex_o   = ce;
    assign reg_write_o = reg_w_i & wrEn;
    assign mem_write_o = mem_w_i & wrEn;
    assign pcsrc_o     = pcs_i & wrEn;
    assign flags_o     = flags_q;
    assign it_active_o = (state_q == ACTIVE);

    // Per-bit flag merge: only requested bits of an executing instruction change.
    always_comb begin
        flags_d = flags_q;
        if (wrEn) begin
            flags_d = (flags_q & ~flag_w_i) | (alu_flags_i & flag_w_i);
        end
    end

    // Block sequencing: open on a legal it_start, consume one slot per fire,
    // close on the last slot, a taken branch, or a flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        base_d  = base_q;
        mask_d  = mask_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (fire) begin
            case (state_q)
                IDLE: begin
                    if (it_start_i && itLenOk) begin
                        state_d = ACTIVE;
                        cnt_d   = it_len_i;
                        idx_d   = '0;
                        base_d  = it_cond_i;
                        mask_d  = it_mask_i;
                    end
                end
                ACTIVE: begin
                    cnt_d = cnt_q - LEN_W'(1);
                    idx_d = idx_q + IDX_W'(1);
                    if ((cnt_q == LEN_W'(1)) || pcsrc_o) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and flag registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: a driver issues one instruction per
// cycle and queues the expected outputs from a slot-list reference model; a
// monitor pops and compares each cycle's outputs.
module tb_cond_exec_unit;

    localparam int FLAG_W   = 4;
    localparam int PRED_MAX = 4;
    localparam int LEN_W    = $clog2(PRED_MAX + 1);

    logic              clk;
    logic              reset;
    logic              valid_i;
    logic              stall_i;
    logic [3:0]        cond_i;
    logic [FLAG_W-1:0] alu_flags_i;
    logic [FLAG_W-1:0] flag_w_i;
    logic              pcs_i;
    logic              reg_w_i;
    logic              mem_w_i;
    logic              it_start_i;
    logic [3:0]        it_cond_i;
    logic [LEN_W-1:0]  it_len_i;
    logic [PRED_MAX-1:0] it_mask_i;
    logic              flush_i;
    logic              pcsrc_o;
    logic              reg_write_o;
    logic              mem_write_o;
    logic              cond_ex_o;
    logic [FLAG_W-1:0] flags_o;
    logic              it_active_o;

    cond_exec_unit #(
        .FLAG_W   (FLAG_W),
        .PRED_MAX (PRED_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .stall_i     (stall_i),
        .cond_i      (cond_i),
        .alu_flags_i (alu_flags_i),
        .flag_w_i    (flag_w_i),
        .pcs_i       (pcs_i),
        .reg_w_i     (reg_w_i),
        .mem_w_i     (mem_w_i),
        .it_start_i  (it_start_i),
        .it_cond_i   (it_cond_i),
        .it_len_i    (it_len_i),
        .it_mask_i   (it_mask_i),
        .flush_i     (flush_i),
        .pcsrc_o     (pcsrc_o),
        .reg_write_o (reg_write_o),
        .mem_write_o (mem_write_o),
        .cond_ex_o   (cond_ex_o),
        .flags_o     (flags_o),
        .it_active_o (it_active_o)
    );

    typedef struct {
        bit       rst;
        bit       valid;
        bit       stall;
        bit       flush;
        bit [3:0] cond;
        bit [3:0] alu;
        bit [3:0] fw;
        bit       pcs;
        bit       regw;
        bit       memw;
        bit       its;
        bit [3:0] itc;
        bit [2:0] itl;
        bit [3:0] itm;
    } stim_t;

    typedef struct {
        bit       pcsrc;
        bit       regw;
        bit       memw;
        bit       ce;
        bit [3:0] flags;
        bit       active;
    } exp_t;

    exp_t     expQ[$];
    bit [3:0] slotQ[$];
    bit [3:0] mFlags;
    bit       mKnown;
    int       checks;
    int       errors;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit refPass(input bit [3:0] cond, input bit [3:0] f);
        bit n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.valid = 1'b1;
        s.cond  = 4'hE;
        return s;
    endfunction

    // Drive one cycle, queue the expected outputs, then advance the model.
    task automatic applyStimulus(input stim_t s);
        exp_t     e;
        bit       fire;
        bit       active;
        bit       ce;
        bit       wr;
        bit [3:0] c;
        @(negedge clk);
        reset       = s.rst;
        valid_i     = s.valid;
        stall_i     = s.stall;
        flush_i     = s.flush;
        cond_i      = s.cond;
        alu_flags_i = s.alu;
        flag_w_i    = s.fw;
        pcs_i       = s.pcs;
        reg_w_i     = s.regw;
        mem_w_i     = s.memw;
        it_start_i  = s.its;
        it_cond_i   = s.itc;
        it_len_i    = s.itl;
        it_mask_i   = s.itm;

        fire   = s.valid && !s.stall && !s.flush;
        active = (slotQ.size() > 0);
        c      = s.cond;
        if (active) c = slotQ[0];
        ce = refPass(c, mFlags);
        wr = fire && ce && !s.its && !s.rst;

        e.pcsrc  = s.pcs && wr;
        e.regw   = s.regw && wr;
        e.memw   = s.memw && wr;
        e.ce     = ce;
        e.flags  = mFlags;
        e.active = active;
        if (mKnown) expQ.push_back(e);

        if (s.rst) begin
            mFlags = 4'h0;
            slotQ.delete();
            mKnown = 1'b1;
        end else if (s.flush) begin
            slotQ.delete();
        end else if (fire) begin
            if (wr) mFlags = (mFlags & ~s.fw) | (s.alu & s.fw);
            if (active) begin
                void'(slotQ.pop_front());
                if (s.pcs && wr) slotQ.delete();
            end else if (s.its && s.itl >= 1 && s.itl <= PRED_MAX) begin
                for (int k = 0; k < int'(s.itl); k++) begin
                    if (s.itc[3:1] == 3'b111) slotQ.push_back(4'hE);
                    else if (s.itm[k])        slotQ.push_back(s.itc);
                    else                      slotQ.push_back(s.itc ^ 4'h1);
                end
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("pcsrc_o",     int'(pcsrc_o),     int'(e.pcsrc));
        cmp("reg_write_o", int'(reg_write_o), int'(e.regw));
        cmp("mem_write_o", int'(mem_write_o), int'(e.memw));
        cmp("cond_ex_o",   int'(cond_ex_o),   int'(e.ce));
        cmp("flags_o",     int'(flags_o),     int'(e.flags));
        cmp("it_active_o", int'(it_active_o), int'(e.active));
    endtask

    // Monitor: every cycle's combinational outputs are compared mid-low-phase.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        stim_t s;
        checks = 0;
        errors = 0;
        mKnown = 1'b0;
        mFlags = 4'h0;
        reset = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        cond_i = 4'h0; alu_flags_i = '0; flag_w_i = '0; pcs_i = 1'b0;
        reg_w_i = 1'b0; mem_w_i = 1'b0; it_start_i = 1'b0; it_cond_i = 4'h0;
        it_len_i = '0; it_mask_i = '0;

        // Reset with EQ + reg_w: no write, flags cleared.
        s = nop(); s.rst = 1; s.cond = 4'd0; s.regw = 1;
        repeat (3) applyStimulus(s);
        s = nop(); s.cond = 4'd0; s.regw = 1; applyStimulus(s);
        s = nop(); s.fw = 4'hF; s.alu = 4'b0100; applyStimulus(s);
        s = nop(); s.cond = 4'd0; s.regw = 1; applyStimulus(s);

        // N=1, V=0: GE fails, LT passes.
        s = nop(); s.fw = 4'hF; s.alu = 4'b1000; applyStimulus(s);
        s = nop(); s.cond = 4'd10; s.memw = 1; applyStimulus(s);
        s = nop(); s.cond = 4'd11; s.memw = 1; applyStimulus(s);

        // EQ block, len 3, mask 101 with Z=1.
        s = nop(); s.fw = 4'hF; s.alu = 4'b0100; applyStimulus(s);
        s = nop(); s.its = 1; s.itc = 4'd0; s.itl = 3; s.itm = 4'b0101; s.regw = 1;
        applyStimulus(s);
        s = nop(); s.regw = 1; s.cond = 4'd1;
        repeat (4) applyStimulus(s);

        // Len 4 AL block with a 3-cycle stall on slot 2.
        s = nop(); s.its = 1; s.itc = 4'hE; s.itl = 4; s.itm = 4'b0000; applyStimulus(s);
        s = nop(); s.regw = 1;
        repeat (2) applyStimulus(s);
        s.stall = 1;
        repeat (3) applyStimulus(s);
        s.stall = 0;
        repeat (3) applyStimulus(s);

        // Taken branch in slot 1 ends the block.
        s = nop(); s.its = 1; s.itc = 4'd0; s.itl = 3; s.itm = 4'b0111; applyStimulus(s);
        s = nop(); s.regw = 1; applyStimulus(s);
        s = nop(); s.pcs = 1; applyStimulus(s);
        s = nop(); s.regw = 1; applyStimulus(s);

        // Flush mid-block, then reset mid-block.
        s = nop(); s.its = 1; s.itc = 4'd1; s.itl = 3; s.itm = 4'b0111; applyStimulus(s);
        s = nop(); s.regw = 1; applyStimulus(s);
        s = nop(); s.flush = 1; s.regw = 1; applyStimulus(s);
        s = nop(); s.regw = 1; applyStimulus(s);
        s = nop(); s.its = 1; s.itc = 4'd0; s.itl = 4; s.itm = 4'b1111; applyStimulus(s);
        s = nop(); s.memw = 1; applyStimulus(s);
        s = nop(); s.rst = 1; s.memw = 1; applyStimulus(s);
        s = nop(); s.cond = 4'd1; s.memw = 1; applyStimulus(s);

        // Only C updated by flag_w 0010.
        s = nop(); s.fw = 4'b0010; s.alu = 4'b1111; applyStimulus(s);
        s = nop(); s.cond = 4'd2; s.regw = 1; applyStimulus(s);

        // Illegal lengths, and it_start consumed as a slot inside a block.
        s = nop(); s.its = 1; s.itl = 0; s.regw = 1; applyStimulus(s);
        s = nop(); s.its = 1; s.itl = 5; s.regw = 1; applyStimulus(s);
        s = nop(); s.its = 1; s.itc = 4'hE; s.itl = 2; applyStimulus(s);
        s = nop(); s.its = 1; s.itc = 4'd0; s.itl = 3; s.regw = 1; applyStimulus(s);
        s = nop(); s.regw = 1;
        repeat (2) applyStimulus(s);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 99) < 2);
            s.valid = ($urandom_range(0, 9) != 0);
            s.stall = ($urandom_range(0, 99) < 15);
            s.flush = ($urandom_range(0, 99) < 4);
            s.cond  = 4'($urandom);
            s.alu   = 4'($urandom);
            s.fw    = 4'($urandom);
            s.pcs   = ($urandom_range(0, 9) == 0);
            s.regw  = 1'($urandom);
            s.memw  = 1'($urandom);
            s.its   = ($urandom_range(0, 99) < 20);
            s.itc   = 4'($urandom);
            s.itl   = 3'($urandom_range(0, 7));
            s.itm   = 4'($urandom);
            applyStimulus(s);
        end

        repeat (2) @(negedge clk);
        #3;
        cmp("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
